operand_fetch: RTL and testbench

- Register-read stage directly downstream of the core's 32-entry synchronous-read register file.
- Accepts decoded instructions with source register indices, drives the two register-file read ports, and absorbs the file's one-cycle read latency.
- Forwards same-cycle writeback data, which the file's read-during-write returns stale.
- Presents registered operands plus passthrough payload to execute over a valid/ready handshake, with full throughput and stall/flush support.

---
 rtl/operand_fetch.sv | 136 +++++++++++++
 tb/tb_operand_fetch.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/operand_fetch.sv
// Register-read stage: drives the synchronous-read register file, absorbs its one-cycle latency,
// forwards writeback data the file would return stale, and hands registered operands to execute.
module operand_fetch #(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDR_WIDTH    = 5,
    parameter int PAYLOAD_WIDTH = 64
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [ADDR_WIDTH-1:0]    in_rs1,
    input  logic [ADDR_WIDTH-1:0]    in_rs2,
    input  logic [PAYLOAD_WIDTH-1:0] in_payload,
    output logic [ADDR_WIDTH-1:0]    rf_r0_addr,
    output logic [ADDR_WIDTH-1:0]    rf_r1_addr,
    input  logic [DATA_WIDTH-1:0]    rf_r0_data,
    input  logic [DATA_WIDTH-1:0]    rf_r1_data,
    input  logic                     wb_en,
    input  logic [ADDR_WIDTH-1:0]    wb_addr,
    input  logic [DATA_WIDTH-1:0]    wb_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DATA_WIDTH-1:0]    out_op_a,
    output logic [DATA_WIDTH-1:0]    out_op_b,
    output logic [PAYLOAD_WIDTH-1:0] out_payload
);

    logic                     s1_valid;
    logic [ADDR_WIDTH-1:0]    s1_rs1;
    logic [ADDR_WIDTH-1:0]    s1_rs2;
    logic [PAYLOAD_WIDTH-1:0] s1_payload;
    logic                     s1_fwd_a;
    logic                     s1_fwd_b;
    logic [DATA_WIDTH-1:0]    s1_fwd_a_data;
    logic [DATA_WIDTH-1:0]    s1_fwd_b_data;
    logic [ADDR_WIDTH-1:0]    out_rs1;
    logic [ADDR_WIDTH-1:0]    out_rs2;

    logic                     out_adv;
    logic                     s1_adv;
    logic                     s1_hold;
    logic                     accept;
    logic                     rd_hit_a;
    logic                     rd_hit_b;
    logic                     s1_hit_a;
    logic                     s1_hit_b;
    logic                     out_hit_a;
    logic                     out_hit_b;
    logic [DATA_WIDTH-1:0]    sel_a;
    logic [DATA_WIDTH-1:0]    sel_b;

    assign out_adv  = !out_valid || out_ready;
    assign s1_adv   = s1_valid && out_adv;
    assign s1_hold  = s1_valid && !s1_adv;
    assign in_ready = !s1_valid || out_adv;
    assign accept   = in_valid && in_ready;

    // A holding S1 re-reads its own indices so the file data always matches S1 next cycle.
    assign rf_r0_addr = accept ? in_rs1 : s1_rs1;
    assign rf_r1_addr = accept ? in_rs2 : s1_rs2;

    assign rd_hit_a  = wb_en && (wb_addr == rf_r0_addr) && (rf_r0_addr != '0);
    assign rd_hit_b  = wb_en && (wb_addr == rf_r1_addr) && (rf_r1_addr != '0);
    assign s1_hit_a  = wb_en && (wb_addr == s1_rs1) && (s1_rs1 != '0);
    assign s1_hit_b  = wb_en && (wb_addr == s1_rs2) && (s1_rs2 != '0);
    assign out_hit_a = wb_en && (wb_addr == out_rs1) && (out_rs1 != '0);
    assign out_hit_b = wb_en && (wb_addr == out_rs2) && (out_rs2 != '0);

    always_comb begin
        sel_a = rf_r0_data;
        sel_b = rf_r1_data;
        if (s1_rs1 == '0)  sel_a = '0;
        else if (s1_hit_a) sel_a = wb_data;
        else if (s1_fwd_a) sel_a = s1_fwd_a_data;
        if (s1_rs2 == '0)  sel_b = '0;
        else if (s1_hit_b) sel_b = wb_data;
        else if (s1_fwd_b) sel_b = s1_fwd_b_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid      <= 1'b0;
            s1_rs1        <= '0;
            s1_rs2        <= '0;
            s1_payload    <= '0;
            s1_fwd_a      <= 1'b0;
            s1_fwd_b      <= 1'b0;
            s1_fwd_a_data <= '0;
            s1_fwd_b_data <= '0;
        end else begin
            if (accept) begin
                s1_rs1     <= in_rs1;
                s1_rs2     <= in_rs2;
                s1_payload <= in_payload;
            end
            // The file returns pre-write data for a same-cycle write; remember that write here.
            if (accept || s1_hold) begin
                s1_fwd_a      <= rd_hit_a;
                s1_fwd_b      <= rd_hit_b;
                s1_fwd_a_data <= wb_data;
                s1_fwd_b_data <= wb_data;
            end
            if (flush)       s1_valid <= 1'b0;
            else if (accept) s1_valid <= 1'b1;
            else if (s1_adv) s1_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid   <= 1'b0;
            out_op_a    <= '0;
            out_op_b    <= '0;
            out_payload <= '0;
            out_rs1     <= '0;
            out_rs2     <= '0;
        end else begin
            if (s1_adv) begin
                out_op_a    <= sel_a;
                out_op_b    <= sel_b;
                out_payload <= s1_payload;
                out_rs1     <= s1_rs1;
                out_rs2     <= s1_rs2;
            end else if (out_valid && !out_ready) begin
                if (out_hit_a) out_op_a <= wb_data;
                if (out_hit_b) out_op_b <= wb_data;
            end
            if (flush)        out_valid <= 1'b0;
            else if (s1_adv)  out_valid <= 1'b1;
            else if (out_adv) out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_operand_fetch.sv
// Directed bench for operand_fetch: a behavioural synchronous-read register file feeds the stage,
// and each vector or sequence compares emitted operands against hand-computed values.
module tb_operand_fetch;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  in_rs1;
    logic [4:0]  in_rs2;
    logic [63:0] in_payload;
    logic [4:0]  rf_r0_addr;
    logic [4:0]  rf_r1_addr;
    logic [31:0] rf_r0_data;
    logic [31:0] rf_r1_data;
    logic        wb_en;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_op_a;
    logic [31:0] out_op_b;
    logic [63:0] out_payload;

    int n_checks = 0;
    int n_fail   = 0;

    operand_fetch #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .PAYLOAD_WIDTH(64)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .in_payload(in_payload),
        .rf_r0_addr(rf_r0_addr), .rf_r1_addr(rf_r1_addr),
        .rf_r0_data(rf_r0_data), .rf_r1_data(rf_r1_data),
        .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_op_a(out_op_a), .out_op_b(out_op_b), .out_payload(out_payload)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous-read file: a read in the write cycle returns the old value.
    logic [31:0] rf_mem [32];
    always_ff @(posedge clk) begin
        rf_r0_data <= rf_mem[rf_r0_addr];
        rf_r1_data <= rf_mem[rf_r1_addr];
        if (wb_en && wb_addr != 5'd0) rf_mem[wb_addr] <= wb_data;
    end

    typedef struct {
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [63:0] payload;
        int          wb_when;
        logic [4:0]  wb_addr;
        logic [31:0] wb_data;
        logic [31:0] exp_a;
        logic [31:0] exp_b;
    } vec_t;

    vec_t vecs [10];

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input int idx, input vec_t v);
        @(negedge clk);
        in_valid   = 1'b1;
        in_rs1     = v.rs1;
        in_rs2     = v.rs2;
        in_payload = v.payload;
        wb_en      = (v.wb_when == 0);
        wb_addr    = v.wb_addr;
        wb_data    = v.wb_data;
        #1;
        checkOutput($sformatf("v%0d_in_ready", idx), 64'(in_ready), 64'd1);
        @(negedge clk);
        in_valid = 1'b0;
        wb_en    = (v.wb_when == 1);
        #1;
        checkOutput($sformatf("v%0d_early_valid", idx), 64'(out_valid), 64'd0);
        @(negedge clk);
        wb_en = 1'b0;
        #1;
        checkOutput($sformatf("v%0d_out_valid", idx), 64'(out_valid), 64'd1);
        checkOutput($sformatf("v%0d_op_a", idx), 64'(out_op_a), 64'(v.exp_a));
        checkOutput($sformatf("v%0d_op_b", idx), 64'(out_op_b), 64'(v.exp_b));
        checkOutput($sformatf("v%0d_payload", idx), out_payload, v.payload);
    endtask

    function automatic logic [31:0] preload_value(input int i);
        if (i == 5) return 32'h11;
        if (i == 6) return 32'h22;
        if (i == 7) return 32'h77;
        return 32'h1000 + 32'(i);
    endfunction

    task automatic send(input logic [4:0] rs1, input logic [4:0] rs2, input logic [63:0] pl);
        in_valid   = 1'b1;
        in_rs1     = rs1;
        in_rs2     = rs2;
        in_payload = pl;
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [4:0]  st_rs1 [4];
        logic [4:0]  st_rs2 [4];
        logic [31:0] st_exp_a [4];
        logic [31:0] st_exp_b [4];
        logic [31:0] got_a [4];
        logic [31:0] got_b [4];
        logic [63:0] got_pl [4];
        int          n_got;
        int          sent;

        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_rs1 = '0; in_rs2 = '0;
        in_payload = '0; wb_en = 1'b0; wb_addr = '0; wb_data = '0; out_ready = 1'b1;

        // Preload the file through its write port while the stage sits in reset.
        for (int i = 1; i < 32; i++) begin
            @(negedge clk);
            wb_en = 1'b1; wb_addr = 5'(i); wb_data = preload_value(i);
        end
        @(negedge clk);
        wb_en = 1'b0; rst = 1'b0; in_rs1 = 5'd3; in_rs2 = 5'd4;
        #1;
        checkOutput("rst_out_valid", 64'(out_valid), 64'd0);
        checkOutput("rst_op_a", 64'(out_op_a), 64'd0);
        checkOutput("rst_op_b", 64'(out_op_b), 64'd0);
        checkOutput("rst_payload", out_payload, 64'd0);
        checkOutput("rst_in_ready", 64'(in_ready), 64'd1);
        checkOutput("rst_r0_addr", 64'(rf_r0_addr), 64'd0);
        checkOutput("rst_r1_addr", 64'(rf_r1_addr), 64'd0);

        // wb_when: 0 = same cycle as accept, 1 = cycle after accept, 2 = no writeback.
        vecs[0] = '{5'd5,  5'd6,  64'hABC,  2, 5'd0,  32'h0,    32'h11,   32'h22};
        vecs[1] = '{5'd5,  5'd6,  64'hABD,  0, 5'd5,  32'h99,   32'h99,   32'h22};
        vecs[2] = '{5'd8,  5'd6,  64'hABE,  1, 5'd8,  32'h99,   32'h99,   32'h22};
        vecs[3] = '{5'd0,  5'd6,  64'hABF,  0, 5'd0,  32'hFFFF, 32'h0,    32'h22};
        vecs[4] = '{5'd0,  5'd0,  64'h1234_5678_9ABC_DEF0, 1, 5'd0, 32'hFFFF, 32'h0, 32'h0};
        vecs[5] = '{5'd9,  5'd9,  64'hC0,   0, 5'd9,  32'hDEAD, 32'hDEAD, 32'hDEAD};
        vecs[6] = '{5'd10, 5'd10, 64'hC1,   1, 5'd10, 32'hBEEF, 32'hBEEF, 32'hBEEF};
        vecs[7] = '{5'd3,  5'd31, 64'hC2,   0, 5'd31, 32'h1234, 32'h1003, 32'h1234};
        vecs[8] = '{5'd9,  5'd8,  64'hFFFF_FFFF_FFFF_FFFF, 2, 5'd0, 32'h0, 32'hDEAD, 32'h99};
        vecs[9] = '{5'd12, 5'd0,  64'hC4,   0, 5'd13, 32'h5,    32'h100C, 32'h0};

        for (int i = 0; i < 10; i++) applyStimulus(i, vecs[i]);

        // Back-to-back stream with a 3-cycle stall; the held OUT entry (rs2 = 7) sees a writeback.
        st_rs1 = '{5'd1, 5'd3, 5'd4, 5'd6};
        st_rs2 = '{5'd2, 5'd7, 5'd5, 5'd11};
        st_exp_a = '{32'h1001, 32'h1003, 32'h1004, 32'h22};
        st_exp_b = '{32'h1002, 32'h55,   32'h99,   32'h100B};
        for (int i = 0; i < 4; i++) begin
            got_a[i] = '0; got_b[i] = '0; got_pl[i] = '0;
        end
        n_got = 0;
        sent  = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            out_ready = !(c >= 3 && c <= 5);
            if (sent < 4) send(st_rs1[sent], st_rs2[sent], 64'h100 + 64'(sent));
            else in_valid = 1'b0;
            wb_en = (c == 3); wb_addr = 5'd7; wb_data = 32'h55;
            #1;
            checkOutput($sformatf("stall_in_ready_c%0d", c), 64'(in_ready),
                        (c >= 3 && c <= 5) ? 64'd0 : 64'd1);
            if (out_valid && out_ready) begin
                if (n_got < 4) begin
                    got_a[n_got] = out_op_a; got_b[n_got] = out_op_b; got_pl[n_got] = out_payload;
                end
                n_got++;
            end
            if (in_valid && in_ready) sent++;
        end
        in_valid = 1'b0; wb_en = 1'b0; out_ready = 1'b1;
        checkOutput("stall_count", 64'(n_got), 64'd4);
        for (int i = 0; i < 4; i++) begin
            checkOutput($sformatf("stall_op_a_%0d", i), 64'(got_a[i]), 64'(st_exp_a[i]));
            checkOutput($sformatf("stall_op_b_%0d", i), 64'(got_b[i]), 64'(st_exp_b[i]));
            checkOutput($sformatf("stall_payload_%0d", i), got_pl[i], 64'h100 + 64'(i));
        end

        // Flush with both stages full; the instruction offered in the flush cycle is discarded.
        @(negedge clk); out_ready = 1'b0; send(5'd1, 5'd2, 64'h3000);
        @(negedge clk); send(5'd3, 5'd4, 64'h3001);
        @(negedge clk); in_valid = 1'b0; #1;
        checkOutput("flush_full_in_ready", 64'(in_ready), 64'd0);
        out_ready = 1'b1; flush = 1'b1; send(5'd6, 5'd6, 64'h3002); #1;
        checkOutput("flush_cycle_in_ready", 64'(in_ready), 64'd1);
        @(negedge clk); flush = 1'b0; send(5'd5, 5'd7, 64'h3333); #1;
        checkOutput("flush_out_valid", 64'(out_valid), 64'd0);
        checkOutput("flush_after_in_ready", 64'(in_ready), 64'd1);
        @(negedge clk); in_valid = 1'b0; #1;
        checkOutput("flush_s1_empty", 64'(out_valid), 64'd0);
        @(negedge clk); #1;
        checkOutput("flush_next_valid", 64'(out_valid), 64'd1);
        checkOutput("flush_next_op_a", 64'(out_op_a), 64'h99);
        checkOutput("flush_next_op_b", 64'(out_op_b), 64'h55);
        checkOutput("flush_next_payload", out_payload, 64'h3333);

        // Reset with both stages full drops everything.
        @(negedge clk); out_ready = 1'b0; send(5'd1, 5'd2, 64'h4000);
        @(negedge clk); send(5'd3, 5'd4, 64'h4001);
        @(negedge clk); in_valid = 1'b0; rst = 1'b1;
        @(negedge clk); rst = 1'b0; #1;
        checkOutput("midrst_out_valid", 64'(out_valid), 64'd0);
        checkOutput("midrst_op_a", 64'(out_op_a), 64'd0);
        checkOutput("midrst_op_b", 64'(out_op_b), 64'd0);
        checkOutput("midrst_payload", out_payload, 64'd0);
        checkOutput("midrst_in_ready", 64'(in_ready), 64'd1);
        out_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk); #1;
            checkOutput($sformatf("midrst_quiet_%0d", c), 64'(out_valid), 64'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
